// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared types and constants for the FFT frame controller
package fas_pkg;
  localparam int FRAME_LEN      = 16;
  localparam int FRAMES_DEFAULT = 64;
  localparam int IDX_W          = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FFT_RUN = 2'd1,
    ANA_RUN = 2'd2,
    DONE    = 2'd3
  } fsm_state_t;
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - sample, frame-buffer and engine handshake bundle
interface fft_frame_ctrl_if;
  import fas_pkg::*;

  logic             fir_valid;
  logic [15:0]      fir_d;
  logic             buf_we;
  logic             buf_bank;
  logic [IDX_W-1:0] buf_addr;
  logic [15:0]      buf_wdata;
  logic             fft_start;
  logic             fft_bank;
  logic             fft_done;
  logic             ana_start;
  logic             ana_done;
  logic [3:0]       ana_freq;
  logic [3:0]       freq;
  logic             done;
  logic             overflow;

  modport slave (
    input  fir_valid, fir_d, fft_done, ana_done, ana_freq,
    output buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
           ana_start, freq, done, overflow
  );

  modport master (
    output fir_valid, fir_d, fft_done, ana_done, ana_freq,
    input  buf_we, buf_bank, buf_addr, buf_wdata, fft_start, fft_bank,
           ana_start, freq, done, overflow
  );
endinterface

// File: rtl/fas_frame_wr.sv
// rtl/fas_frame_wr.sv - ping-pong frame writer: write pointer, full flags, overflow
module fas_frame_wr
  import fas_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [15:0]      i_data,
  input  logic             i_clr,
  input  logic             i_clr_bank,
  output logic             o_we,
  output logic             o_bank,
  output logic [IDX_W-1:0] o_addr,
  output logic [15:0]      o_wdata,
  output logic [1:0]       o_full,
  output logic             o_overflow
);
  logic             r_we;
  logic             r_bank;
  logic [IDX_W-1:0] r_addr;
  logic [15:0]      r_wdata;
  logic             r_overflow;
  logic             r_wr_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [1:0]       r_full;

  logic       w_accept;
  logic       w_drop;
  logic       w_last;
  logic [1:0] w_full_nxt;

  assign w_accept = i_en & i_valid & ~r_full[r_wr_bank];
  assign w_drop   = i_en & i_valid &  r_full[r_wr_bank];
  assign w_last   = (r_wr_idx == IDX_W'(FRAME_LEN - 1));

  // Set is applied after clear so it wins when both hit the same bank.
  always_comb begin
    w_full_nxt = r_full;
    if (i_clr)
      w_full_nxt[i_clr_bank] = 1'b0;
    if (w_accept && w_last)
      w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_bank     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_overflow <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_full     <= '0;
    end else begin
      r_we   <= w_accept;
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_bank   <= r_wr_bank;
        r_addr   <= r_wr_idx;
        r_wdata  <= i_data;
        r_wr_idx <= w_last ? '0 : r_wr_idx + IDX_W'(1);
        if (w_last)
          r_wr_bank <= ~r_wr_bank;
      end
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  assign o_we       = r_we;
  assign o_bank     = r_bank;
  assign o_addr     = r_addr;
  assign o_wdata    = r_wdata;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer: fills ping-pong banks, runs FFT then analysis per frame
module fft_frame_ctrl
  import fas_pkg::*;
#(
  parameter int FRAMES = FRAMES_DEFAULT
)(
  input  logic              clk,
  input  logic              rst,
  fft_frame_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(FRAMES) + 1;

  fsm_state_t       r_state;
  logic             r_rd_bank;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_fft_start;
  logic             r_fft_bank;
  logic             r_ana_start;
  logic [3:0]       r_freq;
  logic             r_done;

  fsm_state_t       w_state_nxt;
  logic             w_rd_bank_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_fft_start_nxt;
  logic             w_fft_bank_nxt;
  logic             w_ana_start_nxt;
  logic [3:0]       w_freq_nxt;
  logic             w_clr;
  logic [1:0]       w_full;
  logic             w_wr_en;

  // Sample intake stops for good once the run is complete.
  assign w_wr_en = (r_state != DONE);

  fas_frame_wr u_frame_wr (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_wr_en),
    .i_valid    (bus.fir_valid),
    .i_data     (bus.fir_d),
    .i_clr      (w_clr),
    .i_clr_bank (r_rd_bank),
    .o_we       (bus.buf_we),
    .o_bank     (bus.buf_bank),
    .o_addr     (bus.buf_addr),
    .o_wdata    (bus.buf_wdata),
    .o_full     (w_full),
    .o_overflow (bus.overflow)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_bank_nxt   = r_rd_bank;
    w_cnt_nxt       = r_frame_cnt;
    w_fft_start_nxt = 1'b0;
    w_fft_bank_nxt  = r_fft_bank;
    w_ana_start_nxt = 1'b0;
    w_freq_nxt      = r_freq;
    w_clr           = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_full[r_rd_bank]) begin
          w_state_nxt     = FFT_RUN;
          w_fft_start_nxt = 1'b1;
          w_fft_bank_nxt  = r_rd_bank;
        end
      end
      FFT_RUN: begin
        if (bus.fft_done) begin
          w_state_nxt     = ANA_RUN;
          w_ana_start_nxt = 1'b1;
        end
      end
      ANA_RUN: begin
        if (bus.ana_done) begin
          w_freq_nxt    = bus.ana_freq;
          w_clr         = 1'b1;
          w_rd_bank_nxt = ~r_rd_bank;
          w_cnt_nxt     = r_frame_cnt + CNT_W'(1);
          w_state_nxt   = (r_frame_cnt == CNT_W'(FRAMES - 1)) ? DONE : IDLE;
        end
      end
      DONE: ;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rd_bank   <= 1'b0;
      r_frame_cnt <= '0;
      r_fft_start <= 1'b0;
      r_fft_bank  <= 1'b0;
      r_ana_start <= 1'b0;
      r_freq      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_fft_start <= w_fft_start_nxt;
      r_fft_bank  <= w_fft_bank_nxt;
      r_ana_start <= w_ana_start_nxt;
      r_freq      <= w_freq_nxt;
      r_done      <= (w_state_nxt == DONE);
    end
  end

  assign bus.fft_start = r_fft_start;
  assign bus.fft_bank  = r_fft_bank;
  assign bus.ana_start = r_ana_start;
  assign bus.freq      = r_freq;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed and randomized bench with a fill-count reference model
module tb_fft_frame_ctrl;
  import fas_pkg::*;

  localparam int FR = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fft_frame_ctrl_if bus ();

  fft_frame_ctrl #(.FRAMES(FR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model: each bank is a fill count 0..16, the read side walks banks in order.
  int          m_fill [2];
  int          m_wb, m_rb, m_phase, m_frames, m_ph0, m_clr_b;
  bit          m_old_full [2];
  bit          m_take;
  logic        e_we, e_bank, e_fs, e_fb, e_as, e_done, e_ovf;
  logic [3:0]  e_addr, e_freq;
  logic [15:0] e_wdata;

  task automatic model_reset();
    m_fill[0] = 0; m_fill[1] = 0;
    m_wb = 0; m_rb = 0; m_phase = 0; m_frames = 0;
    e_we = 0; e_bank = 0; e_addr = 0; e_wdata = 0; e_fs = 0; e_fb = 0;
    e_as = 0; e_freq = 0; e_done = 0; e_ovf = 0;
  endtask

  task automatic model_step();
    m_old_full[0] = (m_fill[0] == FRAME_LEN);
    m_old_full[1] = (m_fill[1] == FRAME_LEN);
    m_ph0 = m_phase;
    m_clr_b = -1;
    e_we = 0; e_fs = 0; e_as = 0;
    case (m_phase)
      0: if (m_old_full[m_rb]) begin m_phase = 1; e_fs = 1; e_fb = m_rb[0]; end
      1: if (bus.fft_done) begin m_phase = 2; e_as = 1; end
      2: if (bus.ana_done) begin
           e_freq = bus.ana_freq;
           m_clr_b = m_rb;
           m_rb = 1 - m_rb;
           m_frames++;
           m_phase = (m_frames == FR) ? 3 : 0;
         end
      default: ;
    endcase
    m_take = 0;
    if (m_ph0 != 3 && bus.fir_valid) begin
      if (m_old_full[m_wb]) e_ovf = 1;
      else m_take = 1;
    end
    if (m_clr_b >= 0) m_fill[m_clr_b] = 0;
    if (m_take) begin
      e_we = 1; e_bank = m_wb[0]; e_addr = 4'(m_fill[m_wb]); e_wdata = bus.fir_d;
      m_fill[m_wb]++;
      if (m_fill[m_wb] == FRAME_LEN) m_wb = 1 - m_wb;
    end
    e_done = (m_phase == 3);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] dvec();
    return {bus.buf_we, bus.buf_bank, bus.buf_addr, bus.buf_wdata, bus.fft_start,
            bus.fft_bank, bus.ana_start, bus.freq, bus.done, bus.overflow};
  endfunction

  function automatic logic [30:0] mvec();
    return {e_we, e_bank, e_addr, e_wdata, e_fs, e_fb, e_as, e_freq, e_done, e_ovf};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) chk("cycle_outputs", 64'(dvec()), 64'(mvec()));
  end

  int n_fs = 0;
  int n_as = 0;
  always @(negedge clk) begin
    if (bus.fft_start) n_fs <= n_fs + 1;
    if (bus.ana_start) n_as <= n_as + 1;
  end

  int fcnt = -1, acnt = -1;
  logic [3:0] last_freq = 4'd0;

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.fir_valid = 1'b0; bus.fft_done = 1'b0; bus.ana_done = 1'b0;
    fcnt = -1; acnt = -1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.fir_valid = 1'b1;
      bus.fir_d = 16'($urandom);
    end
    @(negedge clk);
    bus.fir_valid = 1'b0;
  endtask

  task automatic resp_step(input int fmax, input int amax, input bit spur);
    bus.fft_done = 1'b0;
    bus.ana_done = 1'b0;
    bus.ana_freq = 4'($urandom);
    if (bus.fft_start) fcnt = int'($urandom_range(fmax, 0));
    if (bus.ana_start) acnt = int'($urandom_range(amax, 0));
    if (fcnt == 0) begin bus.fft_done = 1'b1; fcnt = -1; end
    else if (fcnt > 0) fcnt--;
    if (acnt == 0) begin bus.ana_done = 1'b1; last_freq = bus.ana_freq; acnt = -1; end
    else if (acnt > 0) acnt--;
    if (spur && $urandom_range(15, 0) == 0) begin
      if (fcnt < 0 && !bus.fft_done) bus.fft_done = 1'b1;
      else if (acnt < 0 && !bus.ana_done) bus.ana_done = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int as_seen, we_total, we_late, cnt, fs0, found;
    bus.fir_valid = 1'b0; bus.fir_d = '0; bus.fft_done = 1'b0;
    bus.ana_done = 1'b0; bus.ana_freq = '0;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // 16 samples into bank 0, fft_start two edges after the last one
    do_reset();
    chk("reset_outputs", 64'(dvec()), 64'(0));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k > 0) chk("wr_addr", 64'({bus.buf_we, bus.buf_bank, bus.buf_addr}), 64'({1'b1, 1'b0, 4'(k - 1)}));
      bus.fir_valid = 1'b1;
      bus.fir_d = 16'(16'h0101 * k);
    end
    @(negedge clk);
    chk("wr_addr", 64'({bus.buf_we, bus.buf_bank, bus.buf_addr, bus.buf_wdata}), 64'({1'b1, 1'b0, 4'd15, 16'h0f0f}));
    chk("full_after_frame", 64'(dut.w_full), 64'(2'b01));
    chk("no_early_start", 64'(bus.fft_start), 64'(0));
    bus.fir_valid = 1'b0;
    @(negedge clk);
    chk("fft_start_pulse", 64'({bus.fft_start, bus.fft_bank}), 64'(2'b10));

    // fft_done 5 cycles after start, ana_done 3 cycles after ana_start
    as_seen = 0;
    repeat (4) @(negedge clk);
    bus.fft_done = 1'b1;
    @(negedge clk); bus.fft_done = 1'b0;
    chk("ana_start_pulse", 64'(bus.ana_start), 64'(1));
    if (bus.ana_start) as_seen++;
    @(negedge clk); if (bus.ana_start) as_seen++;
    @(negedge clk); if (bus.ana_start) as_seen++;
    bus.ana_done = 1'b1; bus.ana_freq = 4'hF;
    @(negedge clk); bus.ana_done = 1'b0;
    if (bus.ana_start) as_seen++;
    chk("freq_capture", 64'(bus.freq), 64'(4'hF));
    chk("rd_bank_toggle", 64'(dut.r_rd_bank), 64'(1));
    chk("state_idle", 64'(dut.r_state), 64'(IDLE));
    chk("ana_start_count", 64'(as_seen), 64'(1));

    // 48 samples with the engines stalled
    do_reset();
    we_total = 0; we_late = 0;
    for (int k = 0; k <= 48; k++) begin
      @(negedge clk);
      if (bus.buf_we) begin
        we_total++;
        if (k > 32) we_late++;
      end
      bus.fir_valid = (k < 48);
      bus.fir_d = 16'($urandom);
    end
    chk("stall_writes", 64'(we_total), 64'(32));
    chk("stall_late_writes", 64'(we_late), 64'(0));
    chk("stall_overflow", 64'(bus.overflow), 64'(1));
    chk("stall_full", 64'(dut.w_full), 64'(2'b11));

    // FRAMES=4 run with prompt handshakes
    do_reset();
    cnt = 0;
    for (int c = 0; c < 400 && !bus.done; c++) begin
      @(negedge clk);
      resp_step(1, 1, 1'b0);
      bus.fir_valid = (cnt < 64);
      bus.fir_d = 16'($urandom);
      if (cnt < 64) cnt++;
    end
    chk("run_done", 64'(bus.done), 64'(1));
    chk("run_freq", 64'(bus.freq), 64'(last_freq));
    we_total = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.fft_done = 1'b0; bus.ana_done = 1'b0;
      if (bus.buf_we) we_total++;
      bus.fir_valid = 1'b1;
      bus.fir_d = 16'($urandom);
    end
    @(negedge clk);
    bus.fir_valid = 1'b0;
    if (bus.buf_we) we_total++;
    chk("done_ignores_fir", 64'(we_total), 64'(0));
    chk("done_no_overflow", 64'(bus.overflow), 64'(0));
    chk("done_held", 64'(bus.done), 64'(1));

    // reset during FFT_RUN with a partial second frame
    do_reset();
    fs0 = n_fs;
    feed(21);
    @(negedge clk);
    chk("pre_reset_start", 64'(n_fs - fs0), 64'(1));
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", 64'(dvec()), 64'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk); bus.fft_done = 1'b1;
    @(negedge clk); bus.fft_done = 1'b0;
    fs0 = n_fs;
    feed(15);
    repeat (3) @(negedge clk);
    chk("no_pulse_after_reset", 64'({n_fs - fs0, n_as}), 64'({0, n_as}));
    feed(1);
    found = 0;
    for (int i = 0; i < 3 && found == 0; i++) begin
      @(negedge clk);
      if (bus.fft_start) found = 1;
    end
    chk("start_after_new_frame", 64'(found), 64'(1));

    // ana_done lands on the 16th sample of the other bank
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus.fir_valid = 1'b1; bus.fir_d = 16'($urandom);
    end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.fir_valid = 1'b1; bus.fir_d = 16'($urandom);
      bus.fft_done = (c == 3);
      bus.ana_done = (c == 16);
      bus.ana_freq = 4'hA;
    end
    @(negedge clk);
    bus.fir_valid = 1'b0; bus.fft_done = 1'b0; bus.ana_done = 1'b0;
    chk("simul_full", 64'(dut.w_full), 64'(2'b10));
    chk("simul_rd_bank", 64'(dut.r_rd_bank), 64'(1));
    chk("simul_freq", 64'(bus.freq), 64'(4'hA));
    found = 0;
    for (int i = 0; i < 2 && found == 0; i++) begin
      @(negedge clk);
      if (bus.fft_start) found = 1;
    end
    chk("simul_next_start", 64'({found[0], bus.fft_bank}), 64'(2'b11));

    // randomized epochs
    for (int ep = 0; ep < 8; ep++) begin
      int pct, fmax, amax;
      pct  = (ep % 3 == 0) ? 30 : ((ep % 3 == 1) ? 60 : 95);
      fmax = int'($urandom_range(25, 0));
      amax = int'($urandom_range(25, 0));
      do_reset();
      for (int c = 0; c < 250; c++) begin
        @(negedge clk);
        resp_step(fmax, amax, 1'b1);
        bus.fir_valid = ($urandom_range(99, 0) < pct);
        bus.fir_d = 16'($urandom);
      end
    end
    @(negedge clk);
    bus.fir_valid = 1'b0; bus.fft_done = 1'b0; bus.ana_done = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAMES, default 64, meaning the number of 16-sample frames per run (1024 samples).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port fir_valid  input  1  FIR output sample strobe.
REQ-005 SHALL have port fir_d  input  16  FIR sample, signed 8.8 fixed point.
REQ-006 SHALL have port buf_we  output  1  frame-buffer write enable.
REQ-007 SHALL have port buf_bank  output  1  frame-buffer bank being written.
REQ-008 SHALL have port buf_addr  output  4  sample index within the bank.
REQ-009 SHALL have port buf_wdata  output  16  sample to write, equal to fir_d.
REQ-010 SHALL have port fft_start  output  1  one-cycle pulse that launches the FFT.
REQ-011 SHALL have port fft_bank  output  1  bank the FFT reads; stable from fft_start until fft_done.
REQ-012 SHALL have port fft_done  input  1  FFT completion pulse.
REQ-013 SHALL have port ana_start  output  1  one-cycle pulse that launches the analysis.
REQ-014 SHALL have port ana_done  input  1  analysis completion pulse.
REQ-015 SHALL have port ana_freq  input  4  dominant bin, valid with ana_done.
REQ-016 SHALL have port freq  output  4  captured result of the last analysed frame.
REQ-017 SHALL have port done  output  1  level; all FRAMES frames analysed.
REQ-018 SHALL have port overflow  output  1  sticky; a sample was dropped.

Function
REQ-019 SHALL keep a write pointer (wr_bank, wr_idx 0..15) and per-bank full flags full[1:0].
REQ-020 SHALL, on an edge with fir_valid=1 and full[wr_bank]=0: register buf_we=1, buf_bank=wr_bank, buf_addr=wr_idx, buf_wdata=fir_d (write latency 1 cycle), then increment wr_idx.
REQ-021 SHALL, when wr_idx=15 is written: set full[wr_bank] on the same edge, toggle wr_bank, and wrap wr_idx to 0.
REQ-022 SHALL, on fir_valid=1 with full[wr_bank]=1: drop the sample, keep buf_we=0 and the pointer unchanged, and set overflow.
REQ-023 SHALL drive buf_we=0 on every edge without an accepted sample.
REQ-024 SHALL implement the FSM states IDLE, FFT_RUN, ANA_RUN, DONE, with read pointer rd_bank starting at 0.
REQ-025 SHALL, in IDLE with full[rd_bank]=1: go to FFT_RUN and register fft_start=1 and fft_bank=rd_bank for exactly one cycle.
REQ-026 SHALL, in FFT_RUN on fft_done: go to ANA_RUN and register ana_start=1 for one cycle.
REQ-027 SHALL, in ANA_RUN on ana_done: capture freq=ana_freq, clear full[rd_bank], toggle rd_bank, and increment frame_cnt.
REQ-028 SHALL, from that same ana_done edge, go to DONE if frame_cnt was FRAMES-1, else to IDLE.
REQ-029 SHALL ignore fft_done outside FFT_RUN and ana_done outside ANA_RUN.
REQ-030 SHALL, in DONE: hold done=1 and freq, ignore fir_valid (no writes, no overflow), and leave DONE only on rst.
REQ-031 SHALL, when full set (on the 16th sample of the next frame) and full clear (ana_done) fall on the same edge for different banks, apply both.
REQ-032 SHALL give the set priority over the clear if both target the same bank.
REQ-033 SHALL have frame-completion-to-fft_start latency as follows: 16th sample sampled at edge E0; fft_start high between E1 and E2.
REQ-034 SHALL size frame_cnt at clog2(FRAMES)+1 bits so that it never wraps.

Reset
REQ-035 SHALL, on rst: return to IDLE; clear wr_bank, wr_idx, rd_bank, full, and frame_cnt.
REQ-036 SHALL, on rst: drive all outputs to 0 (buf_*, fft_start, fft_bank, ana_start, freq, done, overflow).
REQ-037 SHALL, on rst mid-frame or mid-FFT: discard partial frames, with no pulse emitted after rst deasserts until a new full frame exists.

Structure
REQ-038 SHALL place the state enum, FRAME_LEN=16, and the default FRAMES in shared package fas_pkg.
REQ-039 SHALL use one sub-module, fas_frame_wr (write pointer, full-flag set, overflow); the FSM lives in the top.

Verification
REQ-040 SHALL cover: 16 consecutive fir_valid, fft_done held low -> buf_addr 0..15 on bank 0, full[0]=1, fft_start pulse with fft_bank=0 two edges after the 16th sample.
REQ-041 SHALL cover: fft_done 5 cycles after fft_start, then ana_done with ana_freq=4'hF 3 cycles after ana_start -> ana_start single pulse, freq=15, rd_bank=1, state IDLE.
REQ-042 SHALL cover: 48 continuous samples with FFT/analysis stalled -> banks 0 and 1 full, samples 33..48 dropped, overflow=1, no buf_we.
REQ-043 SHALL cover: FRAMES=4, 64 samples, prompt handshakes -> done=1 after the 4th ana_done, freq equal to the last ana_freq, further fir_valid ignored.
REQ-044 SHALL cover: rst asserted during FFT_RUN -> all outputs 0 immediately (asynchronous), a late fft_done is ignored, and the next fft_start comes only after 16 new samples.
REQ-045 SHALL cover: ana_done on the same edge as the 16th sample of the other bank -> full flags updated for both banks, and the next fft_start for the newly full bank follows within 2 cycles.
